// File: rtl/vpu_src_port.sv
// vpu_src_port: VPU operand-fetch port.
// Streams SRAM rows through a credit-checked FIFO to the lanes.
module vpu_src_port #(
  parameter int OPERAND_WIDTH   = 32,
  parameter int VLANE_CNT       = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int SRAM_RD_LATENCY = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 reset_cmd_i,
  input  logic                                 start_i,
  input  logic [ADDR_WIDTH-1:0]                src_addr_i,
  input  logic [LEN_WIDTH-1:0]                 src_len_i,
  output logic                                 done_o,
  output logic                                 sram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]                sram_rd_addr_o,
  input  logic [OPERAND_WIDTH*VLANE_CNT-1:0]   sram_rd_data_i,
  output logic                                 op_valid_o,
  output logic [OPERAND_WIDTH*VLANE_CNT-1:0]   op_data_o,
  output logic                                 op_last_o,
  input  logic                                 op_ready_i
);
  localparam int DW = OPERAND_WIDTH * VLANE_CNT;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(SRAM_RD_LATENCY + 1);
  localparam int SW = (CW > IW ? CW : IW) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]       deliver_cnt_q, deliver_cnt_d;
  logic                       done_q, done_d;
  logic [SRAM_RD_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              mem_q [FIFO_DEPTH];
  logic [DW-1:0]              mem_d [FIFO_DEPTH];
  logic [IW-1:0]              inflight;
  logic                       credit_ok;
  logic                       rd_en;
  logic                       push;
  logic                       pop;

  assign push           = vld_q[SRAM_RD_LATENCY-1];
  assign op_valid_o     = (cnt_q != '0);
  assign pop            = op_valid_o & op_ready_i;
  assign op_data_o      = op_valid_o ? mem_q[rd_ptr_q] : '0;
  assign op_last_o      = op_valid_o &&
                          (deliver_cnt_q == LEN_WIDTH'(1));
  assign done_o         = done_q;
  assign sram_rd_en_o   = rd_en;
  assign sram_rd_addr_o = addr_q;

  // Issue a read only when buffered plus in-flight rows leave a free slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_RD_LATENCY; i++) begin
      inflight = inflight + IW'(vld_q[i]);
    end
    credit_ok = (SW'(cnt_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
    rd_en = (state_q == S_FETCH) &&
            (issue_cnt_q != '0) && credit_ok;
  end

  // In-flight tracker and operand FIFO; soft reset drops returning data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    vld_d[0] = rd_en;
    for (int i = 1; i < SRAM_RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (push) begin
      mem_d[wr_ptr_q] = sram_rd_data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (reset_cmd_i) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Block sequencing: address/issue counting and delivery tracking.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    done_d        = done_q;
    if (pop) begin
      deliver_cnt_d = deliver_cnt_q - LEN_WIDTH'(1);
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          addr_d        = src_addr_i;
          issue_cnt_d   = src_len_i;
          deliver_cnt_d = src_len_i;
          done_d        = (src_len_i == '0);
          state_d       = (src_len_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_en) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
        end
        if (issue_cnt_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (deliver_cnt_d == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset_cmd_i) begin
      state_d       = S_IDLE;
      addr_d        = '0;
      issue_cnt_d   = '0;
      deliver_cnt_d = '0;
      done_d        = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      done_q        <= 1'b0;
      vld_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      done_q        <= done_d;
      vld_q         <= vld_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
    end
  end

endmodule
